// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply / restoring divide beside the ALU.
// One bit per cycle over WIDTH cycles. The result is returned in a HI/LO pair,
// and a start/busy/done handshake lets the control unit stall the pipeline.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [1:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    cnt_reg;
    logic [1:0]       op_reg;        // bit1: divide, bit0: signed
    logic [WIDTH-1:0] a_reg;         // raw src1, needed for the divide-by-zero remainder
    logic [WIDTH-1:0] b_reg;         // |src2|: multiplicand addend or divisor
    logic [WIDTH-1:0] q_reg;         // multiplier bits / dividend bits, becomes product low / quotient
    logic [WIDTH:0]   acc_reg;       // partial product high half / partial remainder
    logic             neg_res_reg;   // negate product or quotient
    logic             neg_rem_reg;   // negate remainder (dividend was negative)

    logic             last_iter;
    logic             is_div;
    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] hi_res, lo_res;

    assign last_iter = (cnt_reg == CW'(WIDTH - 1));
    assign is_div    = op_reg[1];

    // Magnitudes of the incoming operands; -2^(W-1) maps onto itself as an unsigned value.
    assign src1_mag = (ctrl_i[0] && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign src2_mag = (ctrl_i[0] && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_add   = q_reg[0] ? b_reg : '0;
        mul_sum   = acc_reg + {1'b0, mul_add};
        div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_reg};
        acc_step  = acc_reg;
        q_step    = q_reg;
        if (is_div) begin
            // The partial remainder stays below the divisor, so bit WIDTH of the trial is its sign.
            if (!div_trial[WIDTH]) begin
                acc_step = div_trial;
                q_step   = {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift;
                q_step   = {q_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {1'b0, mul_sum[WIDTH:1]};
            q_step   = {mul_sum[0], q_reg[WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases applied on the final iteration.
    always_comb begin
        prod   = {acc_step[WIDTH-1:0], q_step};
        hi_res = '0;
        lo_res = '0;
        if (!is_div) begin
            {hi_res, lo_res} = neg_res_reg ? -prod : prod;
        end else if (b_reg == '0) begin
            lo_res = '1;
            hi_res = a_reg;
        end else begin
            lo_res = neg_res_reg ? -q_step : q_step;
            hi_res = neg_rem_reg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC for WIDTH edges, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_reg     <= '0;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            q_reg       <= '0;
            acc_reg     <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            hi_o        <= '0;
            lo_o        <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            busy_o <= (state_next != IDLE);
            done_o <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        op_reg      <= ctrl_i;
                        a_reg       <= src1_i;
                        q_reg       <= src1_mag;
                        b_reg       <= src2_mag;
                        acc_reg     <= '0;
                        cnt_reg     <= '0;
                        neg_res_reg <= ctrl_i[0] & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                        neg_rem_reg <= ctrl_i[0] & ctrl_i[1] & src1_i[WIDTH-1];
                        div_zero_o  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_reg <= acc_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_iter) begin
                        hi_o <= hi_res;
                        lo_o <= lo_res;
                        if (is_div && (b_reg == '0)) div_zero_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed HI/LO results.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [1:0]  ctrl_i = '0;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ctrl_i     (ctrl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present operands at a falling edge, let the next rising edge accept them.
    task automatic launch(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; returns the cycle index of done.
    task automatic wait_done(output int n, output int busy_n,
                             output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        n = 1;
        busy_n = 0;
        mid_hi = hi_o;
        mid_lo = lo_o;
        while (!done_o && n < 100) begin
            if (busy_o) busy_n++;
            if (n == 16) begin
                mid_hi = hi_o;
                mid_lo = lo_o;
            end
            @(negedge clk_i);
            n++;
        end
        if (busy_o) busy_n++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int n, busy_n;
        logic [31:0] prev_hi, prev_lo, mid_hi, mid_lo;
        prev_hi = hi_o;
        prev_lo = lo_o;
        launch(c, a, b);
        check({tag, "_dz_clr"}, 64'(div_zero_o), 64'(0));
        wait_done(n, busy_n, mid_hi, mid_lo);
        check({tag, "_lat"}, 64'(n), 64'(33));
        check({tag, "_busy"}, 64'(busy_n), 64'(33));
        check({tag, "_hold"}, {mid_hi, mid_lo}, {prev_hi, prev_lo});
        check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
        check({tag, "_dz"}, 64'(div_zero_o), 64'(exp_dz));
        @(negedge clk_i);
        check({tag, "_pulse"}, {62'd0, done_o, busy_o}, 64'(0));
        $display("op %s ctrl=%0d src1=%h src2=%h -> hi=%h lo=%h dz=%0d", tag, c, a, b, hi_o, lo_o, div_zero_o);
    endtask

    initial begin
        int n, busy_n, pulses;
        logic [31:0] mid_hi, mid_lo;

        // Reset state.
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        check("reset", {30'd0, busy_o, done_o, div_zero_o, hi_o}, 64'(0));
        check("reset_lo", 64'(lo_o), 64'(0));

        run_op("mulu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mul_m7x6", 2'b01, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
        run_op("mulu_m7x6", 2'b00, 32'hFFFFFFF9, 32'd6, 32'h00000005, 32'hFFFFFFD6, 1'b0);
        run_op("mul_m3xm4", 2'b01, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 1'b0);
        run_op("div_m17d5", 2'b11, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_op("div_17dm5", 2'b11, 32'd17, 32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0);
        run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_by0", 2'b10, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF, 1'b1);
        check("dz_hold", 64'(div_zero_o), 64'(1));
        run_op("div_m5by0", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

        // start held high with operands changing every cycle during CALC.
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = 2'b00;
        src1_i  = 32'd3;
        src2_i  = 32'd5;
        @(posedge clk_i);
        n = 1;
        @(negedge clk_i);
        while (!done_o && n < 100) begin
            src1_i = $urandom;
            src2_i = $urandom;
            ctrl_i = 2'($urandom_range(0, 3));
            @(negedge clk_i);
            n++;
        end
        check("hold_lat", 64'(n), 64'(33));
        check("hold_res", {hi_o, lo_o}, 64'd15);
        $display("op hold_start -> hi=%h lo=%h", hi_o, lo_o);
        @(negedge clk_i);
        check("hold_idle_gap", 64'(busy_o), 64'(0));
        ctrl_i = 2'b00;
        src1_i = 32'd2;
        src2_i = 32'd9;
        @(negedge clk_i);
        check("hold_reaccept", 64'(busy_o), 64'(1));
        start_i = 1'b0;
        wait_done(n, busy_n, mid_hi, mid_lo);
        check("hold2_lat", 64'(n), 64'(33));
        check("hold2_res", {hi_o, lo_o}, 64'd18);
        $display("op hold_start_2 -> hi=%h lo=%h", hi_o, lo_o);

        // Reset in the middle of a divide.
        launch(2'b10, 32'd1000, 32'd3);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        check("abort_state", {29'd0, busy_o, done_o, div_zero_o, hi_o}, 64'(0));
        check("abort_lo", 64'(lo_o), 64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) pulses++;
            @(negedge clk_i);
        end
        check("abort_quiet", 64'(pulses), 64'(0));
        $display("op abort_div -> hi=%h lo=%h busy=%0d", hi_o, lo_o, busy_o);
        run_op("mulu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the CPU datapath. It sits beside the combinational ALU.
- Same operand style as the ALU: two 32-bit sources plus an op code. It returns a 64-bit product, or a quotient and remainder, in a HI/LO pair.
- Start/busy/done handshake lets the control unit stall the pipeline until the result is valid.
- Radix-2 shift-add multiply and restoring divide: one bit per cycle.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count = WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous active-low reset
- start_i  in  1  request an operation; accepted only in IDLE
- src1_i  in  WIDTH  multiplicand / dividend
- src2_i  in  WIDTH  multiplier / divisor
- ctrl_i  in  2  00 mulu, 01 mul (signed), 10 divu, 11 div (signed)
- busy_o  out  1  high while an operation is in progress (CALC or DONE)
- done_o  out  1  one-cycle pulse: hi_o/lo_o valid
- hi_o  out  WIDTH  multiply: product[2W-1:W]; divide: remainder
- lo_o  out  WIDTH  multiply: product[W-1:0]; divide: quotient
- div_zero_o  out  1  set with done_o when divisor was 0; held until next accepted start

Behaviour:
- Reset (rst_i=0 at an edge): state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0; iteration counter=0.
- Reset mid-operation: abort, no done_o pulse, all outputs cleared as above.
- States:
  - IDLE: if start_i=1 at edge E0, latch src1_i, src2_i and ctrl_i; compute operand magnitudes (signed ops only); record result signs; clear div_zero_o; counter=0; go to CALC.
  - CALC: one iteration per edge; counter increments. On the edge where counter reaches WIDTH-1 (edge E32 for WIDTH=32), apply the sign fix-up, write hi_o/lo_o, and go to DONE.
  - DONE: done_o=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start accepted at E0, done_o high in the cycle after E32 (WIDTH+1 edges). A new start_i is accepted at the earliest on the edge after DONE.
- busy_o is high in CALC and DONE; low in IDLE. start_i is ignored while busy_o=1, and inputs are not re-sampled.
- hi_o/lo_o hold their last result until the next operation completes. They are not updated during CALC.
- Multiply:
  - Unsigned: 64-bit product of the latched operands.
  - Signed: multiply the magnitudes, then negate the 64-bit result if the operand signs differ.
- Divide (restoring, magnitudes):
  - quotient to lo_o, remainder to hi_o.
  - Signed: quotient is negated if the signs differ. Remainder takes the sign of the dividend (truncating division).
- Divide by zero: same latency.
  - lo_o=all ones, hi_o=latched src1 (both divu and div).
  - div_zero_o=1 from the DONE cycle until the next accepted start.
- Signed overflow (div, -2^(W-1) / -1): lo_o=32'h80000000, hi_o=0, div_zero_o=0.
- Magnitude of -2^(W-1) is handled as an unsigned W-bit value; no extra width is needed beyond a W+1-bit partial remainder.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then mulu src1=32'hFFFFFFFF, src2=32'hFFFFFFFF → after 33 edges done_o=1 for one cycle; hi_o=32'hFFFFFFFE, lo_o=32'h00000001; busy_o high for 33 cycles.
- mul signed src1=-7 (32'hFFFFFFF9), src2=6 → hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFD6 (-42). mulu with the same operands → hi_o=32'h00000005, lo_o=32'hFFFFFFD6.
- div signed src1=-17, src2=5 → lo_o=32'hFFFFFFFD (-3), hi_o=32'hFFFFFFFE (-2). divu src1=100, src2=7 → lo_o=14, hi_o=2.
- divu src1=1234, src2=0 → lo_o=32'hFFFFFFFF, hi_o=1234, div_zero_o=1. The next start clears div_zero_o. Signed div 32'h80000000 / 32'hFFFFFFFF → lo_o=32'h80000000, hi_o=0.
- start_i held high continuously with changing operands → only the first operands are used. The next operation starts on the edge after DONE; no start is accepted during CALC.
- rst_i=0 for one edge at iteration 10 of a divide → busy_o=0, hi_o/lo_o=0, no done_o pulse. A fresh mulu 3×4 then completes with lo_o=12.
